fp_round_pack: RTL and testbench

Rounding and packing stage for the 12-bit-integer to 8-bit floating-point converter, directly downstream of the exponent/significand extraction stage. Accepts a sign bit, a 3-bit exponent, a 4-bit significand and the fifth (rounding) bit, and rounds half-up with exponent carry and saturation. Packs the result as `{S, E[2:0], F[3:0]}` and buffers it in a small output queue behind a valid/ready handshake. Also keeps a saturating count of overflow-clamped conversions for debug.

---
 rtl/fp_round_pack.sv | 55 +++++
 tb/tb_fp_round_pack.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// fp_round_pack: half-up rounding with exponent carry/saturation, packed into a small valid/ready output queue
module fp_round_pack #(
  parameter int DEPTH = 2,
  parameter int SAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [2:0]       in_exp,
  input  logic [3:0]       in_frac,
  input  logic             in_fifth,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_fp,
  output logic [SAT_W-1:0] sat_cnt,
  input  logic             sat_clr
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic [CW-1:0] count;
  logic [4:0]    s;
  logic [7:0]    packed_fp;
  logic          clamp, push, pop;
  always_comb begin
    s = {1'b0, in_frac} + {4'b0, in_fifth};
    clamp = s[4] && (in_exp == 3'd7);
    packed_fp = !s[4] ? {in_sign, in_exp, s[3:0]} :
                clamp ? {in_sign, 7'h7f} : {in_sign, in_exp + 3'd1, 4'b1000};
  end
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign out_fp    = out_valid ? mem[rd] : 8'h00;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr      <= '0;
      rd      <= '0;
      count   <= '0;
      sat_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wr] <= packed_fp;
        wr      <= wr == PW'(DEPTH - 1) ? '0 : wr + 1'b1;
      end
      if (pop) rd <= rd == PW'(DEPTH - 1) ? '0 : rd + 1'b1;
      count   <= count + CW'(push) - CW'(pop);
      sat_cnt <= sat_clr ? '0 : (push && clamp && sat_cnt != '1) ? sat_cnt + 1'b1 : sat_cnt;
    end
endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: directed and random checks of fp_round_pack against a queue-based reference model
module tb_fp_round_pack;
  localparam int DEPTH = 2;
  localparam int SAT_W = 8;
  localparam int SATMAX = (1 << SAT_W) - 1;
  logic clk = 0, rst_n, in_valid, in_ready, in_sign, in_fifth, out_valid, out_ready, sat_clr;
  logic [2:0] in_exp;
  logic [3:0] in_frac;
  logic [7:0] out_fp;
  logic [SAT_W-1:0] sat_cnt;
  int errors = 0, checks = 0, msat = 0;
  logic [7:0] q[$];

  fp_round_pack #(.DEPTH(DEPTH), .SAT_W(SAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_fifth(in_fifth),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp),
    .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rounding from the arithmetic rules: add the fifth bit, carry bumps the exponent, overflow clamps.
  function automatic logic [7:0] ref_pack(input logic sg, input int e, input int f, input int fi,
                                          output logic cl);
    int r, ne, nf;
    r = f + fi;
    cl = 0;
    if (r < 16) begin ne = e; nf = r; end
    else if (e < 7) begin ne = e + 1; nf = 8; end
    else begin ne = 7; nf = 15; cl = 1; end
    return 8'(int'(sg) * 128 + ne * 16 + nf);
  endfunction

  task automatic cyc(input logic v, input logic sg, input logic [2:0] e, input logic [3:0] f,
                     input logic fi, input logic ordy, input logic clr);
    logic [7:0] p;
    logic cl, rdy, pu, po;
    in_valid = v; in_sign = sg; in_exp = e; in_frac = f; in_fifth = fi;
    out_ready = ordy; sat_clr = clr;
    @(negedge clk);
    rdy = q.size() != DEPTH;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_fp", 32'(out_fp), 32'(q.size() != 0 ? q[0] : 8'h00));
    chk("sat_cnt", 32'(sat_cnt), 32'(msat));
    p = ref_pack(sg, int'(e), int'(f), int'(fi), cl);
    pu = v && rdy;
    po = q.size() != 0 && ordy;
    @(posedge clk);
    #1;
    if (po) void'(q.pop_front());
    if (pu) q.push_back(p);
    if (clr) msat = 0;
    else if (pu && cl && msat < SATMAX) msat++;
  endtask

  initial begin
    rst_n = 0; in_valid = 1; in_sign = 1; in_exp = 3'd7; in_frac = 4'hf; in_fifth = 1;
    out_ready = 1; sat_clr = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_fp", 32'(out_fp), 0);
      chk("rst_sat_cnt", 32'(sat_cnt), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
    end
    in_valid = 0;
    rst_n = 1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("idle_out_valid", 32'(out_valid), 0);
    // basic rounding and exponent carry
    cyc(1, 0, 3'd3, 4'b1010, 1, 1, 0);
    chk("basic_3b", 32'(out_fp), 32'h3B);
    cyc(1, 1, 3'd2, 4'b0110, 0, 1, 0);
    chk("basic_a6", 32'(out_fp), 32'hA6);
    cyc(1, 0, 3'd4, 4'b1111, 1, 1, 0);
    chk("carry_58", 32'(out_fp), 32'h58);
    chk("carry_sat", 32'(sat_cnt), 0);
    cyc(1, 1, 3'd0, 4'b0000, 0, 1, 0);
    chk("neg_zero", 32'(out_fp), 32'h80);
    cyc(0, 0, 0, 0, 0, 1, 0);
    // saturation
    cyc(1, 1, 3'd7, 4'b1111, 1, 1, 0);
    chk("sat_ff", 32'(out_fp), 32'hFF);
    chk("sat_one", 32'(sat_cnt), 1);
    repeat (300) cyc(1, 1, 3'd7, 4'b1111, 1, 1, 0);
    chk("sat_hold", 32'(sat_cnt), 255);
    cyc(1, 1, 3'd7, 4'b1111, 1, 1, 1);
    chk("sat_clr", 32'(sat_cnt), 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    // backpressure
    cyc(1, 0, 3'd1, 4'b0001, 0, 0, 0);
    cyc(1, 0, 3'd2, 4'b0010, 0, 0, 0);
    chk("bp_full", 32'(in_ready), 0);
    cyc(1, 0, 3'd3, 4'b0011, 0, 0, 0);
    chk("bp_hold", 32'(out_fp), 32'h11);
    cyc(1, 0, 3'd3, 4'b0011, 0, 1, 0);
    chk("bp_ready_back", 32'(in_ready), 1);
    cyc(1, 0, 3'd3, 4'b0011, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);
    chk("bp_drained", 32'(out_valid), 0);
    // asynchronous reset mid-operation
    cyc(1, 0, 3'd7, 4'b1111, 1, 0, 0);
    cyc(1, 0, 3'd5, 4'b0100, 0, 0, 0);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_fp", 32'(out_fp), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_sat", 32'(sat_cnt), 0);
    q.delete();
    msat = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    // random streaming
    for (int i = 0; i < 1000; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, 1) != 0 ? 3'd7 : 3'($urandom),
          4'($urandom_range(0, 3) == 0 ? 15 : $urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 49) == 0));
    repeat (DEPTH + 1) cyc(0, 0, 0, 0, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
